// File: rtl/tlul_pkg.sv
// Shared TL-UL types, opcodes and host-adapter constants.
package tlul_pkg;

    localparam int unsigned TAG_W           = 2;
    localparam int unsigned SRC_ID_W        = 6;
    localparam int unsigned SOURCE_W        = SRC_ID_W + TAG_W;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ASEND = 2'b01,
        ST_DWAIT = 2'b10
    } host_state_e;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'h0,
        PUT_PARTIAL_DATA = 3'h1,
        GET              = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'h0,
        ACCESS_ACK_DATA = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [1:0]          a_size;
        logic [SOURCE_W-1:0] a_source;
        logic [31:0]         a_address;
        logic [3:0]          a_mask;
        logic [31:0]         a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [SOURCE_W-1:0] d_source;
        logic [31:0]         d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // A-channel opcode for a captured request.
    function automatic logic [2:0] a_opcode_sel(input logic we, input logic [3:0] be);
        logic [2:0] op;
        if (!we) begin
            op = GET;
        end else if (be == 4'hF) begin
            op = PUT_FULL_DATA;
        end else begin
            op = PUT_PARTIAL_DATA;
        end
        return op;
    endfunction

    // True when the D opcode does not suit the outstanding request type.
    function automatic logic d_opcode_bad(input logic we, input logic [2:0] d_op);
        logic bad;
        if (we) begin
            bad = (d_op != ACCESS_ACK);
        end else begin
            bad = (d_op != ACCESS_ACK_DATA);
        end
        return bad;
    endfunction

endpackage

// File: rtl/tlul_timeout_cnt.sv
// Response timeout counter: counts enabled cycles and flags the last allowed one.
module tlul_timeout_cnt
    import tlul_pkg::*;
#(
    parameter int unsigned Limit = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_L = CNT_W'(Limit - 1);

    logic [CNT_W-1:0] cnt_r;

    assign expired = enable && (cnt_r == LAST_L);

    // Cycle counter; saturates at the last allowed cycle until cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/tlul_host_adapter.sv
// Bridges a simple req/gnt master onto TL-UL with a single outstanding
// transaction, tagged sources and a response timeout.
module tlul_host_adapter
    import tlul_pkg::*;
#(
    parameter int unsigned TimeoutCycles = TIMEOUT_DEFAULT,
    parameter int unsigned SourceId      = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam logic [SRC_ID_W-1:0] SRC_ID_L = SRC_ID_W'(SourceId);

    host_state_e      state_r;
    host_state_e      state_nxt_s;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       be_r;
    logic [TAG_W-1:0] tag_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             valid_r;
    logic             err_r;
    logic [31:0]      rdata_r;

    logic             gnt_s;
    logic             cap_en_s;
    logic             a_hs_s;
    logic             done_s;
    logic             done_err_s;
    logic [31:0]      done_rdata_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             cnt_exp_s;
    logic             d_match_s;
    logic             d_op_bad_s;
    logic             unused_s;

    // Low address bits are never forwarded; the A address is word aligned.
    assign unused_s   = ^addr_i[1:0];
    assign d_match_s  = tl_i.d_valid && (tl_i.d_source == {SRC_ID_L, out_tag_r});
    assign d_op_bad_s = d_opcode_bad(we_r, tl_i.d_opcode);

    tlul_timeout_cnt #(
        .Limit (TimeoutCycles)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (cnt_clr_s),
        .enable  (cnt_en_s),
        .expired (cnt_exp_s)
    );

    // Next-state and per-cycle control decode; a matching D beat outranks expiry.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_s        = 1'b0;
        cap_en_s     = 1'b0;
        a_hs_s       = 1'b0;
        done_s       = 1'b0;
        done_err_s   = 1'b0;
        done_rdata_s = 32'h0;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_i && !rst_i) begin
                    gnt_s       = 1'b1;
                    cap_en_s    = 1'b1;
                    state_nxt_s = ST_ASEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASEND: begin
                if (tl_i.a_ready) begin
                    a_hs_s      = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_DWAIT;
                end else begin
                    state_nxt_s = ST_ASEND;
                end
            end
            ST_DWAIT: begin
                cnt_en_s = 1'b1;
                if (d_match_s) begin
                    done_s      = 1'b1;
                    done_err_s  = tl_i.d_error | d_op_bad_s;
                    if (!we_r && !(tl_i.d_error | d_op_bad_s)) begin
                        done_rdata_s = tl_i.d_data;
                    end else begin
                        done_rdata_s = 32'h0;
                    end
                    state_nxt_s = ST_IDLE;
                end else if (cnt_exp_s) begin
                    done_s       = 1'b1;
                    done_err_s   = 1'b1;
                    done_rdata_s = 32'h0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DWAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture so the A fields stay stable while the device stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0;
            wdata_r <= 32'h0;
            be_r    <= 4'h0;
        end else if (cap_en_s) begin
            we_r    <= we_i;
            addr_r  <= {addr_i[31:2], 2'b00};
            wdata_r <= wdata_i;
            be_r    <= be_i;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    // Source tag: remember the one in flight, then advance for the next request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_r     <= {TAG_W{1'b0}};
            out_tag_r <= {TAG_W{1'b0}};
        end else if (a_hs_s) begin
            tag_r     <= tag_r + TAG_W'(1);
            out_tag_r <= tag_r;
        end else begin
            tag_r     <= tag_r;
            out_tag_r <= out_tag_r;
        end
    end

    // Response registers; data and error hold between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0;
        end else begin
            valid_r <= done_s;
            if (done_s) begin
                err_r   <= done_err_s;
                rdata_r <= done_rdata_s;
            end else begin
                err_r   <= err_r;
                rdata_r <= rdata_r;
            end
        end
    end

    assign gnt_o   = gnt_s;
    assign valid_o = valid_r;
    assign err_o   = err_r;
    assign rdata_o = rdata_r;

    assign tl_o.a_valid   = (state_r == ST_ASEND);
    assign tl_o.a_opcode  = a_opcode_sel(we_r, be_r);
    assign tl_o.a_param   = 3'h0;
    assign tl_o.a_size    = 2'd2;
    assign tl_o.a_source  = {SRC_ID_L, tag_r};
    assign tl_o.a_address = addr_r;
    assign tl_o.a_mask    = we_r ? be_r : 4'hF;
    assign tl_o.a_data    = we_r ? wdata_r : 32'h0;
    assign tl_o.d_ready   = 1'b1;

endmodule
